// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit.
// Runs a 32-step shift-add multiply or restoring divide on operand magnitudes, then applies
// sign correction and registers the selected 32-bit result.
// Ports:
//   clk, reset          - clock, synchronous active-high reset
//   start               - request pulse, sampled only while idle
//   funct3              - RV32M operation select (MUL..REMU)
//   op_a, op_b          - rs1 / rs2 operands
//   busy                - high whenever the unit is not idle
//   done                - one-cycle pulse, result valid
//   result              - registered result, held until the next completion
module muldiv_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  funct3,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e      state;
  logic [2:0]  f3;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [5:0]  cnt;
  logic [63:0] prod;
  logic [31:0] rem;
  logic [31:0] quo;

  logic        in_sa, in_sb;
  logic [31:0] in_a_mag, in_b_mag;
  logic        div_zero, div_ovf;
  logic [31:0] special_res;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;
  logic [31:0] final_res;

  always_comb begin
    // MULH, MULHSU, DIV, REM treat op_a as signed; MULH, DIV, REM also op_b.
    in_sa = op_a[31] & ((funct3 == 3'b001) | (funct3 == 3'b010) |
                        (funct3 == 3'b100) | (funct3 == 3'b110));
    in_sb = op_b[31] & ((funct3 == 3'b001) | (funct3 == 3'b100) | (funct3 == 3'b110));
    in_a_mag = in_sa ? -op_a : op_a;
    in_b_mag = in_sb ? -op_b : op_b;

    div_zero = funct3[2] & (op_b == 32'd0);
    div_ovf  = funct3[2] & ~funct3[0] & (op_a == 32'h8000_0000) & (op_b == 32'hFFFF_FFFF);
    if (div_zero) special_res = funct3[1] ? op_a : 32'hFFFF_FFFF;
    else          special_res = funct3[1] ? 32'd0 : 32'h8000_0000;

    // Multiply step: conditionally add multiplicand to the upper half, then shift right.
    mul_sum = {1'b0, prod[63:32]} + (prod[0] ? {1'b0, a_mag} : 33'd0);

    // Divide step: bring in the next dividend bit; restore by simply not subtracting.
    div_shift = {rem, quo[31]};
    div_ge    = div_shift >= {1'b0, b_mag};

    prod_fix = (sign_a ^ sign_b) ? -prod : prod;
    quo_fix  = (sign_a ^ sign_b) ? -quo : quo;
    rem_fix  = sign_a ? -rem : rem;

    if (!f3[2]) final_res = (f3[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    else        final_res = f3[1] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= StIdle;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= 32'd0;
      cnt    <= 6'd0;
      f3     <= 3'd0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      a_mag  <= 32'd0;
      b_mag  <= 32'd0;
      prod   <= 64'd0;
      rem    <= 32'd0;
      quo    <= 32'd0;
    end else begin
      unique case (state)
        StIdle: begin
          done <= 1'b0;
          if (start) begin
            f3     <= funct3;
            sign_a <= in_sa;
            sign_b <= in_sb;
            a_mag  <= in_a_mag;
            b_mag  <= in_b_mag;
            cnt    <= 6'd0;
            prod   <= {32'd0, in_b_mag};
            rem    <= 32'd0;
            quo    <= in_a_mag;
            busy   <= 1'b1;
            if (div_zero || div_ovf) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= StDone;
            end else begin
              state <= StCalc;
            end
          end
        end
        StCalc: begin
          // cnt reaches 32 after the last iteration; that edge finalises the result.
          if (cnt == 6'd32) begin
            result <= final_res;
            done   <= 1'b1;
            state  <= StDone;
          end else begin
            cnt <= cnt + 6'd1;
            if (f3[2]) begin
              if (div_ge) begin
                rem <= div_shift[31:0] - b_mag;
                quo <= {quo[30:0], 1'b1};
              end else begin
                rem <= div_shift[31:0];
                quo <= {quo[30:0], 1'b0};
              end
            end else begin
              prod <= {mul_sum, prod[31:1]};
            end
          end
        end
        StDone: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: the driver pushes expected result and completion cycle,
// a negedge monitor pops and compares on every done pulse and checks result stability.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        busy;
  logic        done;
  logic [31:0] result;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .busy  (busy),
    .done  (done),
    .result(result)
  );

  typedef struct {
    logic [31:0] res;
    int unsigned at;
  } exp_t;

  exp_t        sb[$];
  exp_t        e_mon;
  int          checks = 0;
  int          fails = 0;
  int unsigned cyc = 0;
  logic        rst_edge = 1'b1;
  logic        prev_done = 1'b0;
  logic [31:0] last_res = 32'd0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_edge <= reset;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model straight from the RV32M definitions.
  function automatic logic [31:0] ref_op(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] b);
    longint          sa, sbv;
    longint unsigned ua, ub;
    logic [63:0]     p;
    logic            ovf;
    sa  = $signed(a);
    sbv = $signed(b);
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = 64'd0;
    case (f)
      3'd0: begin p = ua * ub;          return p[31:0];  end
      3'd1: begin p = sa * sbv;         return p[63:32]; end
      3'd2: begin p = sa * longint'(ub); return p[63:32]; end
      3'd3: begin p = ua * ub;          return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        p = sa / sbv; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        p = ua / ub; return p[31:0];
      end
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'd0;
        p = sa % sbv; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        p = ua % ub; return p[31:0];
      end
    endcase
  endfunction

  function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                    input logic [31:0] b);
    return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Monitor
  always @(negedge clk) begin
    if (rst_edge) begin
      check("reset_result", result, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_done", {31'd0, done}, 32'd0);
      last_res = 32'd0;
    end else if (done) begin
      check("done_width", {31'd0, prev_done}, 32'd0);
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no completion (cycle %0d)", cyc);
      end else begin
        e_mon = sb.pop_front();
        check("result", result, e_mon.res);
        check("done_cycle", cyc, e_mon.at);
        check("busy_in_done", {31'd0, busy}, 32'd1);
      end
      last_res = result;
    end else begin
      check("result_hold", result, last_res);
    end
    prev_done = done;
  end

  task automatic wait_done();
    int n = 0;
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++;
      fails++;
      $display("FAIL done_timeout: got no done expected done within 60 cycles");
    end
  endtask

  // Issues one request, scrambles inputs after the start edge, returns in the DONE cycle.
  task automatic issue(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    @(negedge clk);
    start  = 1'b1;
    funct3 = f;
    op_a   = a;
    op_b   = b;
    e.res  = ref_op(f, a, b);
    e.at   = cyc + 1 + (is_special(f, a, b) ? 0 : 33);
    sb.push_back(e);
    @(negedge clk);
    start  = 1'b0;
    funct3 = 3'($urandom);
    op_a   = $urandom;
    op_b   = $urandom;
    check("busy_after_start", {31'd0, busy}, 32'd1);
    wait_done();
  endtask

  task automatic idle_check();
    @(negedge clk);
    check("busy_after_done", {31'd0, busy}, 32'd0);
    check("no_done_idle", {31'd0, done}, 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    reset  = 1'b1;
    start  = 1'b0;
    funct3 = 3'd0;
    op_a   = 32'd0;
    op_b   = 32'd0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) begin
      @(negedge clk);
      check("idle_busy", {31'd0, busy}, 32'd0);
      check("idle_done", {31'd0, done}, 32'd0);
    end

    // Directed multiplies and divides
    issue(3'd0, 32'd7, 32'hFFFF_FFFD);         idle_check();
    issue(3'd1, 32'h8000_0000, 32'h8000_0000); idle_check();
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle_check();
    issue(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF); idle_check();
    issue(3'd4, 32'hFFFF_FFF9, 32'd2);         idle_check();
    issue(3'd6, 32'hFFFF_FFF9, 32'd2);         idle_check();
    issue(3'd5, 32'd100, 32'd7);               idle_check();
    issue(3'd7, 32'd100, 32'd7);               idle_check();

    // Special cases
    issue(3'd5, 32'd5, 32'd0);                 idle_check();
    issue(3'd6, 32'd5, 32'd0);                 idle_check();
    issue(3'd4, 32'h8000_0000, 32'hFFFF_FFFF); idle_check();
    issue(3'd6, 32'h8000_0000, 32'hFFFF_FFFF); idle_check();

    // Start while busy is ignored, then a back-to-back start in the first idle cycle
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd0;
    op_a   = 32'd3;
    op_b   = 32'd4;
    e.res  = 32'd12;
    e.at   = cyc + 1 + 33;
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    start  = 1'b1;
    op_a   = 32'd5;
    op_b   = 32'd6;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    issue(3'd0, 32'd9, 32'd9);
    issue(3'd5, 32'd9, 32'd0);
    issue(3'd7, 32'd1000, 32'd33);
    idle_check();

    // Randomised mix
    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom), pick(), pick());
      if ($urandom_range(0, 1) == 1) idle_check();
    end

    // Reset aborts an in-flight divide with no completion
    @(negedge clk);
    start  = 1'b1;
    funct3 = 3'd5;
    op_a   = 32'd1000;
    op_b   = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (13) @(negedge clk);
    check("busy_before_abort", {31'd0, busy}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (45) begin
      @(negedge clk);
      check("abort_busy", {31'd0, busy}, 32'd0);
    end

    check("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
